// File: rtl/byte_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | byte_seq_pkg : shared types and default constants for byte_seq_detector     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package byte_seq_pkg;

  typedef enum logic [0:0] {
    IDLE        = 1'b0,
    WAIT_SECOND = 1'b1
  } state_t;

  localparam logic [7:0] DEF_FIRST_BYTE  = 8'h98;
  localparam logic [7:0] DEF_SECOND_BYTE = 8'h67;
  localparam int         DEF_MAX_GAP     = 4;

  // Gap counter width; a single-cycle window still needs one bit.
  function automatic int gap_width(input int max_gap);
    return (max_gap > 1) ? $clog2(max_gap) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------------+
// | sat_counter : saturating event counter with sticky overflow flag           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  // clr takes precedence over a simultaneous increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (inc) begin
      if (&r_count) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/byte_seq_detector.sv
// +----------------------------------------------------------------------------+
// | byte_seq_detector : FIRST_BYTE then SECOND_BYTE within MAX_GAP cycles      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module byte_seq_detector
  import byte_seq_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] FIRST_BYTE  = DEF_FIRST_BYTE,
  parameter logic [DATA_W-1:0] SECOND_BYTE = DEF_SECOND_BYTE,
  parameter int                MAX_GAP     = DEF_MAX_GAP,
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              match,
  output logic              armed,
  output logic [CNT_W-1:0]  match_count,
  output logic              overflow
);

  localparam int               c_gap_w    = gap_width(MAX_GAP);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(MAX_GAP - 1);

  generate
    if (FIRST_BYTE == SECOND_BYTE) begin : g_chk_bytes
      $error("byte_seq_detector: FIRST_BYTE must differ from SECOND_BYTE");
    end
    if (MAX_GAP < 1) begin : g_chk_gap
      $error("byte_seq_detector: MAX_GAP must be at least 1");
    end
  endgenerate

  state_t             r_state;
  logic [c_gap_w-1:0] r_gap;
  logic               r_match;

  logic w_first;
  logic w_second;
  logic w_accept;

  assign w_first  = in_valid && (in_data == FIRST_BYTE);
  assign w_second = in_valid && (in_data == SECOND_BYTE);
  assign w_accept = (r_state == WAIT_SECOND) && w_second;

  // A beat on the last window cycle is evaluated ahead of the timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_gap   <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_first) begin
            r_state <= WAIT_SECOND;
            r_gap   <= '0;
          end
        end
        WAIT_SECOND: begin
          if (w_second) begin
            r_state <= IDLE;
            r_match <= 1'b1;
          end else if (w_first) begin
            r_gap <= '0;
          end else if (in_valid) begin
            r_state <= IDLE;
          end else if (r_gap == c_gap_last) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + c_gap_w'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gap   <= '0;
        end
      endcase
    end
  end

  assign match = r_match;
  assign armed = (r_state == WAIT_SECOND);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_accept),
    .clr      (clear),
    .count    (match_count),
    .overflow (overflow)
  );

endmodule

`default_nettype wire

// File: tb/tb_byte_seq_detector.sv
// +----------------------------------------------------------------------------+
// | tb_byte_seq_detector : directed self-checking bench for byte_seq_detector  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_byte_seq_detector;

  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             clear;
  logic             match;
  logic             armed;
  logic [CNT_W-1:0] match_count;
  logic             overflow;

  int n_checks;
  int n_pass;

  byte_seq_detector #(
    .DATA_W      (8),
    .FIRST_BYTE  (8'h98),
    .SECOND_BYTE (8'h67),
    .MAX_GAP     (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clear       (clear),
    .match       (match),
    .armed       (armed),
    .match_count (match_count),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one cycle of input, then sample just after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1'b0, 8'h00);
    clear = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", match, 0);
    chk("rst_armed", armed, 0);
    chk("rst_count", match_count, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic sequence
    cyc(1'b1, 8'h98);
    chk("basic_armed", armed, 1);
    chk("basic_nomatch_early", match, 0);
    cyc(1'b1, 8'h67);
    chk("basic_match", match, 1);
    chk("basic_count", match_count, 1);
    chk("basic_disarm", armed, 0);
    cyc(1'b0, 8'h00);
    chk("basic_pulse_end", match, 0);
    chk("basic_count_hold", match_count, 1);

    // Window edge: second byte at offset 4 matches
    do_clear();
    cyc(1'b1, 8'h98);
    repeat (3) cyc(1'b0, 8'h00);
    chk("win4_still_armed", armed, 1);
    cyc(1'b1, 8'h67);
    chk("win4_match", match, 1);
    chk("win4_count", match_count, 1);

    // Offset 5 is past the window
    cyc(1'b1, 8'h98);
    repeat (4) cyc(1'b0, 8'h00);
    chk("win5_timeout", armed, 0);
    cyc(1'b1, 8'h67);
    chk("win5_nomatch", match, 0);
    chk("win5_count", match_count, 1);

    // Restart: 98 98 67 -> one match
    cyc(1'b1, 8'h98);
    cyc(1'b1, 8'h98);
    chk("restart_armed", armed, 1);
    chk("restart_nomatch", match, 0);
    cyc(1'b1, 8'h67);
    chk("restart_match", match, 1);
    chk("restart_count", match_count, 2);
    cyc(1'b0, 8'h00);
    chk("restart_single", match, 0);

    // Abort: 98 55 67 -> no match
    cyc(1'b1, 8'h98);
    cyc(1'b1, 8'h55);
    chk("abort_disarm", armed, 0);
    cyc(1'b1, 8'h67);
    chk("abort_nomatch", match, 0);
    chk("abort_count", match_count, 2);

    // Invalid beat carrying SECOND_BYTE is ignored
    cyc(1'b1, 8'h98);
    cyc(1'b0, 8'h67);
    chk("inval_nomatch", match, 0);
    chk("inval_armed", armed, 1);
    cyc(1'b1, 8'h55);
    chk("inval_abort", armed, 0);

    // Saturation with CNT_W=2, back-to-back sequences
    do_clear();
    chk("clr_count", match_count, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h98);
      chk("sat_gap_nomatch", match, 0);
      cyc(1'b1, 8'h67);
      chk("sat_match", match, 1);
    end
    chk("sat_count3", match_count, 3);
    chk("sat_ovf0", overflow, 0);
    cyc(1'b1, 8'h98);
    cyc(1'b1, 8'h67);
    chk("sat_match4", match, 1);
    chk("sat_count_hold", match_count, 3);
    chk("sat_ovf1", overflow, 1);
    do_clear();
    chk("sat_clr_count", match_count, 0);
    chk("sat_clr_ovf", overflow, 0);

    // Async reset mid-sequence
    cyc(1'b1, 8'h98);
    chk("async_pre_armed", armed, 1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_armed", armed, 0);
    chk("async_match", match, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 8'h67);
    chk("async_lone_match", match, 0);
    chk("async_lone_armed", armed, 0);
    chk("async_lone_count", match_count, 0);
    chk("async_lone_ovf", overflow, 0);

    // clear coincident with the accepting beat
    cyc(1'b1, 8'h98);
    cyc(1'b1, 8'h67);
    chk("pre_clr_count", match_count, 1);
    cyc(1'b1, 8'h98);
    clear = 1'b1;
    cyc(1'b1, 8'h67);
    clear = 1'b0;
    chk("coinc_match", match, 1);
    chk("coinc_count", match_count, 0);
    chk("coinc_ovf", overflow, 0);
    cyc(1'b0, 8'h00);
    chk("coinc_pulse_end", match, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/byte_seq_detector.md
Name: byte_seq_detector

Overview:
Downstream consumer of the 8-bit reset-value data register. It watches the registered byte stream for a two-byte sequence, FIRST_BYTE followed by SECOND_BYTE, within a bounded gap. On each completed sequence it emits a one-cycle match pulse and maintains a saturating match counter with a sticky overflow flag, for status and debug logic.

Parameters:
DATA_W, 8, width of in_data.
FIRST_BYTE, 8'h98, first byte of the sequence.
SECOND_BYTE, 8'h67, second byte of the sequence.
MAX_GAP, 4, the second byte is accepted up to MAX_GAP cycles after the first; must be >= 1.
CNT_W, 8, width of match_count.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  in_data is a valid beat this cycle.
in_data  input  DATA_W  registered byte from the upstream data register.
clear  input  1  synchronous clear of match_count and overflow.
match  output  1  one-cycle pulse, the cycle after SECOND_BYTE completes a sequence.
armed  output  1  high while the FSM is in WAIT_SECOND.
match_count  output  CNT_W  number of matches, saturating at all-ones.
overflow  output  1  sticky; set when a match occurs while match_count is all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, gap=0, match=0, armed=0, match_count=0, overflow=0. Reset in WAIT_SECOND abandons the partial sequence immediately.
- Only cycles with in_valid=1 are beats. in_data is ignored when in_valid=0.
- IDLE:
  - beat == FIRST_BYTE -> WAIT_SECOND, gap <= 0.
  - otherwise stay in IDLE.
- WAIT_SECOND (armed=1), evaluated in this priority order:
  - beat == SECOND_BYTE -> IDLE; match=1 in the next cycle.
  - beat == FIRST_BYTE -> stay; gap <= 0 (restart the window).
  - beat of any other value -> IDLE, no match.
  - no beat and gap == MAX_GAP-1 -> IDLE (timeout).
  - no beat, otherwise -> gap <= gap+1.
- Window: with FIRST_BYTE on cycle t, SECOND_BYTE on any cycle t+1..t+MAX_GAP matches. A beat on cycle t+MAX_GAP is evaluated before the timeout.
- gap width: $clog2(MAX_GAP); MAX_GAP=1 uses a 1-bit gap.
- match is registered: high exactly one cycle, the cycle after the accepting beat. Back-to-back sequences give pulses two cycles apart minimum.
- match_count and overflow update on the same edge that raises match:
  - below all-ones: count+1.
  - at all-ones: count holds, overflow <= 1.
- clear=1: match_count <= 0, overflow <= 0. clear wins over a simultaneous increment; the match pulse itself still asserts. clear has no effect on the FSM or gap.
- Parameter checks: FIRST_BYTE != SECOND_BYTE and MAX_GAP >= 1, checked by elaboration-time assertions.
- armed is decoded directly from the state register, with no extra latency.

Decomposition:
- Package byte_seq_pkg:
  - state typedef enum {IDLE, WAIT_SECOND}.
  - default constants DEF_FIRST_BYTE=8'h98, DEF_SECOND_BYTE=8'h67, DEF_MAX_GAP=4.
- Sub-module sat_counter: parameter CNT_W; inputs inc, clr; outputs count, overflow (sticky). Same clk and async active-low reset. Reused elsewhere for status counters.
- byte_seq_detector holds the FSM, the gap counter and the match register, and instantiates one sat_counter.

Test Plan:
- Basic sequence: release reset; beats 0x98 on cycle 0, 0x67 on cycle 1 -> armed=1 on cycle 1; match=1 on cycle 2 only; match_count=1 from cycle 2.
- Window edge (MAX_GAP=4): 0x98, then 3 idle cycles, then 0x67 at offset 4 -> match. Repeat with 0x67 at offset 5 -> no match, armed=0 from cycle 5, count unchanged.
- Restart and abort:
  - 0x98, 0x98, 0x67 -> exactly one match.
  - 0x98, 0x55, 0x67 -> no match, armed=0 after the 0x55 beat.
  - 0x67 with in_valid=0 -> ignored.
- Saturation (CNT_W=2): 3 sequences -> count=3, overflow=0. A 4th -> count=3, overflow=1. Then clear=1 for one cycle -> count=0, overflow=0.
- Async reset mid-sequence: 0x98, then reset=0 mid-cycle -> armed=0 immediately, before the next clk edge. After release, a lone 0x67 -> no match, all outputs 0.
- clear coincident with match: complete a sequence while holding clear=1 on the edge the match registers -> match=1, match_count=0, overflow=0.
